// File: rtl/eth_rx_mac_filter.sv
// eth_rx_mac_filter: destination-MAC filter that buffers the 6-byte header, decides, then replays or drops the frame
module eth_rx_mac_filter #(
  parameter int CNT_WIDTH = 16,
  parameter int ENABLE_MULTICAST = 1
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          cfg_local_mac,
  input  logic                 cfg_promisc,
  input  logic                 cfg_bcast_en,
  input  logic                 cfg_mcast_en,
  output logic                 stat_accept,
  output logic                 stat_drop,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] runt_count
);
  typedef enum logic [2:0] {HDR, DECIDE, REPLAY, PASS, DROP} state_t;
  state_t state, state_nxt;
  logic [2:0] idx;
  logic [7:0] hdr_buf [6];
  logic [47:0] dest;
  logic bcast, accept, in_hs, out_hs, runt, reject;
  assign dest = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], hdr_buf[5]};
  assign bcast = &dest;
  assign accept = cfg_promisc | (dest == cfg_local_mac) | (bcast & cfg_bcast_en)
                | (dest[40] & ~bcast & cfg_mcast_en & (ENABLE_MULTICAST != 0));
  assign s_axis_tready = logic_rst_n & (state == HDR | state == DROP | (state == PASS & m_axis_tready));
  assign m_axis_tvalid = logic_rst_n & (state == REPLAY | (state == PASS & s_axis_tvalid));
  assign m_axis_tdata = state == PASS ? s_axis_tdata : hdr_buf[idx];
  assign m_axis_tlast = state == PASS & s_axis_tlast;
  assign m_axis_tuser = state == PASS & s_axis_tuser;
  assign in_hs = s_axis_tvalid & s_axis_tready;
  assign out_hs = m_axis_tvalid & m_axis_tready;
  assign runt = state == HDR & in_hs & s_axis_tlast;
  assign reject = state == DECIDE & ~accept;
  always_comb begin
    state_nxt = state;
    state_nxt = state == HDR    ? (in_hs & ~s_axis_tlast & idx == 3'd5 ? DECIDE : HDR) :
                state == DECIDE ? (accept ? REPLAY : DROP) :
                state == REPLAY ? (out_hs & idx == 3'd5 ? PASS : REPLAY) :
                in_hs & s_axis_tlast ? HDR : state;
  end
  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state       <= HDR;
      idx         <= 3'd0;
      drop_count  <= '0;
      runt_count  <= '0;
      stat_accept <= 1'b0;
      stat_drop   <= 1'b0;
    end else begin
      state       <= state_nxt;
      stat_accept <= state == DECIDE & accept;
      stat_drop   <= reject | runt;
      if (state == HDR & in_hs) begin
        hdr_buf[idx] <= s_axis_tdata;
        idx          <= s_axis_tlast | idx == 3'd5 ? 3'd0 : idx + 3'd1;
      end
      if (state == REPLAY & out_hs) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
      if (runt & ~&runt_count) runt_count <= runt_count + 1'b1;
      if (reject & ~&drop_count) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// tb_eth_rx_mac_filter: randomized self-checking bench for eth_rx_mac_filter against a frame-level model
module tb_eth_rx_mac_filter;
  logic clk = 1'b0;
  logic rst_n, s_tvalid, s_tlast, s_tuser, m_ready, promisc, bcast_en, mcast_en, sel, bp, gaps;
  logic [7:0] s_tdata;
  logic [47:0] mac;
  logic s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1, m_user0, m_user1;
  logic acc0, acc1, drp0, drp1;
  logic [7:0] m_data0, m_data1;
  logic [15:0] drop_cnt0, runt_cnt0;
  logic [1:0] drop_cnt1, runt_cnt1;
  logic s_ready, m_valid, m_last, m_user, st_acc, st_drp;
  logic [7:0] m_data;
  logic [15:0] dcnt, rcnt;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int checks = 0, fails = 0, acc_n = 0, drp_n = 0, acc_m = 0, drp_m = 0, to_cnt = 0;
  int drop_m[2];
  int runt_m[2];
  eth_rx_mac_filter dut0 (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tready(s_ready0),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last0), .m_axis_tuser(m_user0),
    .cfg_local_mac(mac), .cfg_promisc(promisc), .cfg_bcast_en(bcast_en), .cfg_mcast_en(mcast_en),
    .stat_accept(acc0), .stat_drop(drp0), .drop_count(drop_cnt0), .runt_count(runt_cnt0)
  );
  eth_rx_mac_filter #(.CNT_WIDTH(2), .ENABLE_MULTICAST(0)) dut1 (
    .logic_clk(clk), .logic_rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & sel), .s_axis_tready(s_ready1),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last1), .m_axis_tuser(m_user1),
    .cfg_local_mac(mac), .cfg_promisc(promisc), .cfg_bcast_en(bcast_en), .cfg_mcast_en(mcast_en),
    .stat_accept(acc1), .stat_drop(drp1), .drop_count(drop_cnt1), .runt_count(runt_cnt1)
  );
  assign s_ready = sel ? s_ready1 : s_ready0;
  assign m_valid = sel ? m_valid1 : m_valid0;
  assign m_last  = sel ? m_last1 : m_last0;
  assign m_user  = sel ? m_user1 : m_user0;
  assign m_data  = sel ? m_data1 : m_data0;
  assign st_acc  = sel ? acc1 : acc0;
  assign st_drp  = sel ? drp1 : drp0;
  assign dcnt    = sel ? {14'd0, drop_cnt1} : drop_cnt0;
  assign rcnt    = sel ? {14'd0, runt_cnt1} : runt_cnt0;
  initial forever #5 clk = ~clk;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_valid && m_ready) obs_q.push_back({m_user, m_last, m_data});
    if (st_acc) acc_n++;
    if (st_drp) drp_n++;
  end
  function automatic bit model_accept(input logic [47:0] a);
    bit bc = 1'b1, uc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bc &= (a[47-8*i -: 8] == 8'hFF);
      uc &= (a[47-8*i -: 8] == mac[47-8*i -: 8]);
    end
    return promisc | uc | (bc & bcast_en) | (a[40] & ~bc & mcast_en & ~sel);
  endfunction
  function automatic int stream_diff();
    int d = (exp_q.size() != obs_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) if (exp_q[i] !== obs_q[i]) d++;
    return d;
  endfunction
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
    int n = 0;
    if (gaps) while ($urandom_range(0, 2) == 0) begin
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_tdata = d;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 500);
    if (!s_ready) to_cnt++;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask
  task automatic send_frame(input logic [47:0] dst, input int len, input logic u);
    logic [7:0] f[$];
    int n = 0;
    int mx = sel ? 3 : 65535;
    for (int i = 0; i < len; i++) f.push_back(i < 6 ? dst[47-8*i -: 8] : 8'($urandom));
    if (len <= 6) begin
      if (runt_m[sel] < mx) runt_m[sel]++;
      drp_m++;
    end else if (model_accept(dst)) begin
      acc_m++;
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1 ? u : 1'b0, i == len - 1, f[i]});
    end else begin
      if (drop_m[sel] < mx) drop_m[sel]++;
      drp_m++;
    end
    for (int i = 0; i < len; i++) send_byte(f[i], i == len - 1, i == len - 1 ? u : 1'b0);
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (obs_q.size() < exp_q.size()) to_cnt++;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b0 || s_ready1 !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b/%b expected 0/0", s_ready0, s_ready1); end
    checks++;
    if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b/%b expected 0/0", m_valid0, m_valid1); end
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b1) begin fails++; $display("FAIL idle_tready: got %b expected 1", s_ready0); end
    checks++;
    if (drop_cnt0 !== 16'd0 || runt_cnt0 !== 16'd0 || acc0 !== 1'b0 || drp0 !== 1'b0)
      begin fails++; $display("FAIL reset_counters: got drop %0d runt %0d acc %b drp %b expected all 0", drop_cnt0, runt_cnt0, acc0, drp0); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_unicast();
    send_frame(mac, 64, 1'b0);
    checks++;
    if (obs_q.size() != 64 || stream_diff() != 0) begin fails++; $display("FAIL unicast_stream: got %0d bytes (%0d bad) expected 64", obs_q.size(), stream_diff()); end
    checks++;
    if (acc_n !== acc_m) begin fails++; $display("FAIL unicast_accept_pulses: got %0d expected %0d", acc_n, acc_m); end
    checks++;
    if (dcnt !== 16'd0 || rcnt !== 16'd0) begin fails++; $display("FAIL unicast_counters: got %0d/%0d expected 0/0", dcnt, rcnt); end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_bcast_mcast();
    send_frame(48'hFFFFFFFFFFFF, 20, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL bcast_off_output: got %0d bytes expected 0", obs_q.size()); end
    checks++;
    if (dcnt !== 16'(drop_m[0]) || dcnt !== 16'd1) begin fails++; $display("FAIL bcast_off_drop_count: got %0d expected %0d", dcnt, drop_m[0]); end
    checks++;
    if (to_cnt !== 0) begin fails++; $display("FAIL bcast_off_consumed: got %0d stalls expected 0", to_cnt); end
    bcast_en = 1'b1;
    send_frame(48'hFFFFFFFFFFFF, 20, 1'b0);
    checks++;
    if (stream_diff() != 0) begin fails++; $display("FAIL bcast_on_stream: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
    exp_q.delete();
    obs_q.delete();
    mcast_en = 1'b1;
    send_frame(48'h01005E000001, 30, 1'b0);
    checks++;
    if (obs_q.size() != 30 || stream_diff() != 0) begin fails++; $display("FAIL mcast_enabled_stream: got %0d bytes expected 30", obs_q.size()); end
    exp_q.delete();
    obs_q.delete();
    sel = 1'b1;
    send_frame(48'h01005E000001, 30, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL mcast_disabled_output: got %0d bytes expected 0", obs_q.size()); end
    checks++;
    if (dcnt !== 16'(drop_m[1])) begin fails++; $display("FAIL mcast_disabled_drop_count: got %0d expected %0d", dcnt, drop_m[1]); end
    sel = 1'b0;
    mcast_en = 1'b0;
    bcast_en = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_runts();
    int d0 = drp_n;
    send_frame(mac, 4, 1'b0);
    send_frame(mac, 6, 1'b0);
    send_frame(mac, 60, 1'b0);
    checks++;
    if (rcnt !== 16'(runt_m[0]) || rcnt !== 16'd2) begin fails++; $display("FAIL runt_count: got %0d expected %0d", rcnt, runt_m[0]); end
    checks++;
    if (drp_n - d0 !== 2) begin fails++; $display("FAIL runt_drop_pulses: got %0d expected 2", drp_n - d0); end
    checks++;
    if (obs_q.size() != 60 || stream_diff() != 0) begin fails++; $display("FAIL runt_then_frame_stream: got %0d bytes expected 60", obs_q.size()); end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_backpressure();
    logic [47:0] d;
    bp = 1'b1;
    gaps = 1'b1;
    send_frame(mac, 30, 1'b1);
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: d = mac;
        1: d = 48'hFFFFFFFFFFFF;
        2: d = {24'h01005E, 24'($urandom)};
        default: d = {16'($urandom), 32'($urandom)} & ~48'h010000000000;
      endcase
      promisc = ($urandom_range(0, 7) == 0);
      bcast_en = 1'($urandom_range(0, 1));
      mcast_en = 1'($urandom_range(0, 1));
      send_frame(d, $urandom_range(1, 80), 1'($urandom_range(0, 1)));
    end
    bp = 1'b0;
    gaps = 1'b0;
    promisc = 1'b0;
    bcast_en = 1'b0;
    mcast_en = 1'b0;
    checks++;
    if (stream_diff() != 0) begin fails++; $display("FAIL bp_stream: got %0d bytes (%0d bad) expected %0d", obs_q.size(), stream_diff(), exp_q.size()); end
    checks++;
    if (exp_q.size() < 30 || obs_q.size() < 30 || obs_q[29] !== exp_q[29]) begin fails++; $display("FAIL bp_tuser_last: got %0d bytes expected tuser frame first", obs_q.size()); end
    checks++;
    if (dcnt !== 16'(drop_m[0]) || rcnt !== 16'(runt_m[0])) begin fails++; $display("FAIL bp_counters: got %0d/%0d expected %0d/%0d", dcnt, rcnt, drop_m[0], runt_m[0]); end
    checks++;
    if (acc_n !== acc_m || drp_n !== drp_m) begin fails++; $display("FAIL bp_pulses: got %0d/%0d expected %0d/%0d", acc_n, drp_n, acc_m, drp_m); end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_saturation();
    sel = 1'b1;
    for (int k = 0; k < 5; k++) send_frame(48'h0A0000000099, 10, 1'b0);
    for (int k = 0; k < 4; k++) send_frame(mac, 3, 1'b0);
    checks++;
    if (dcnt !== 16'd3 || dcnt !== 16'(drop_m[1])) begin fails++; $display("FAIL sat_drop_count: got %0d expected 3", dcnt); end
    checks++;
    if (rcnt !== 16'd3 || rcnt !== 16'(runt_m[1])) begin fails++; $display("FAIL sat_runt_count: got %0d expected 3", rcnt); end
    promisc = 1'b1;
    send_frame(48'h0A0000000099, 12, 1'b0);
    checks++;
    if (obs_q.size() != 12 || stream_diff() != 0) begin fails++; $display("FAIL promisc_stream: got %0d bytes expected 12", obs_q.size()); end
    checks++;
    if (dcnt !== 16'd3) begin fails++; $display("FAIL sat_hold: got %0d expected 3", dcnt); end
    promisc = 1'b0;
    sel = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) send_byte(i < 6 ? mac[47-8*i -: 8] : 8'(i), 1'b0, 1'b0);
    acc_m++;
    s_tdata = 8'd20;
    s_tlast = 1'b0;
    s_tvalid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid0 !== 1'b0 || s_ready0 !== 1'b0) begin fails++; $display("FAIL midreset_outputs: got tvalid %b tready %b expected 0/0", m_valid0, s_ready0); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_tvalid = 1'b0;
    drop_m = '{0, 0};
    runt_m = '{0, 0};
    @(negedge clk);
    checks++;
    if (drop_cnt0 !== 16'd0 || runt_cnt0 !== 16'd0 || m_valid0 !== 1'b0) begin fails++; $display("FAIL midreset_counters: got %0d/%0d tvalid %b expected 0/0/0", drop_cnt0, runt_cnt0, m_valid0); end
    @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    send_frame(mac, 64, 1'b0);
    checks++;
    if (obs_q.size() != 64 || stream_diff() != 0) begin fails++; $display("FAIL midreset_next_frame: got %0d bytes expected 64", obs_q.size()); end
    checks++;
    if (acc_n !== acc_m || to_cnt !== 0) begin fails++; $display("FAIL final_pulses_stalls: got acc %0d stalls %0d expected %0d/0", acc_n, to_cnt, acc_m); end
  endtask
  initial begin
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = 8'd0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    sel = 1'b0;
    bp = 1'b0;
    gaps = 1'b0;
    mac = 48'h020000000001;
    promisc = 1'b0;
    bcast_en = 1'b0;
    mcast_en = 1'b0;
    drop_m = '{0, 0};
    runt_m = '{0, 0};
    @(posedge clk);
    #1;
    test_reset();
    test_unicast();
    test_bcast_mcast();
    test_runts();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
